fifo_rd_streamer: RTL and testbench

// - Sits directly downstream of the synchronous FIFO and drains its read port.
// - Converts the FIFO read interface (rd_en / data_out / empty, 1-cycle read

---
 rtl/fifo_rd_streamer_pkg.sv | 19 +
 rtl/stream_skid_buf.sv | 70 +++++++
 rtl/fifo_rd_streamer.sv | 80 ++++++++
 tb/tb_fifo_rd_streamer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
//   FIFO_WIDTH_DEF : default data width, matching the upstream FIFO data_out
//   SKID_DEPTH     : entries in the elastic buffer behind the FIFO read port
//   fifo_word_t    : one FIFO word at the default width
//   occ_next()     : buffer occupancy after a push and/or pop
package fifo_rd_streamer_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned SKID_DEPTH     = 2;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

  function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                          input logic       push,
                                          input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered elastic buffer with occupancy count.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous reset, active-HIGH (1 = reset)
//   push      : write push_data at the tail this cycle
//   push_data : word to append
//   pop       : drop the head entry this cycle (only legal while occ != 0)
//   occ       : number of valid entries, 0..2
//   head_data : oldest entry; 0 after reset
module stream_skid_buf
  import fifo_rd_streamer_pkg::*;
#(
  parameter int unsigned Width = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [Width-1:0] head_data
);

  logic [Width-1:0] mem_q [SKID_DEPTH];
  logic [Width-1:0] mem_d [SKID_DEPTH];
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    occ_d = occ_next(occ_q, push, pop);
    case ({push, pop})
      // Tail slot is entry 0 when empty, entry 1 when one word is held.
      2'b10: mem_d[occ_q[0]] = push_data;
      2'b01: mem_d[0] = mem_q[1];
      2'b11: begin
        if (occ_q == 2'd2) begin
          mem_d[0] = mem_q[1];
          mem_d[1] = push_data;
        end else begin
          mem_d[0] = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      occ_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[0];

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (occ_q <= 2'(SKID_DEPTH));
      assert (!(push && (occ_q == 2'(SKID_DEPTH)) && !pop));
    end
  end
`endif

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 2-entry elastic buffer, and frames beats into fixed-length bursts.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active-HIGH (1 = reset)
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en : FIFO read enable (combinational)
//   m_valid    : stream valid
//   m_ready    : stream ready from sink
//   m_data     : stream data (buffer head)
//   m_last     : final beat of the current burst
//   beat_cnt   : beats already accepted in the current burst
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [7:0]            beat_cnt
);

  localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);

  logic       inflight_q, inflight_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] occ;
  logic       pop;
  logic [2:0] committed;

  stream_skid_buf #(
    .Width(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data(fifo_data),
    .pop      (pop),
    .occ      (occ),
    .head_data(m_data)
  );

  always_comb begin
    // Outputs are gated during reset so nothing is offered or read that cycle.
    m_valid = !rst_n && (occ != 2'd0);
    pop     = m_valid && m_ready;
    // Buffer slots already spoken for next cycle: held words, plus the word
    // arriving from the FIFO, minus the one leaving now.
    committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = !rst_n && !fifo_empty && (committed < 3'd2);
    inflight_d = fifo_rd_en;
    m_last     = m_valid && (beat_cnt_q == LastBeat);
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LastBeat) ? 8'd0 : beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= 8'd0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;
  import fifo_rd_streamer_pkg::*;

  localparam int BL = 4;

  logic       clk, rst_n, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last;
  fifo_word_t fifo_data, m_data;
  logic [7:0] beat_cnt;

  fifo_rd_streamer #(
    .FIFO_WIDTH(16),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: fifo_q is the upstream FIFO contents, exp_q the words read out
  // of it and not yet delivered, in order.
  fifo_word_t fifo_q[$];
  fifo_word_t exp_q[$];
  int rd_cum_p1 = 0;  // successful reads issued up to last cycle
  int rd_cum_p2 = 0;  // successful reads issued up to two cycles ago
  int xfers = 0;
  int total_xfers = 0;
  int rd_pulses = 0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int first_v_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic fe);
    logic       exp_valid, exp_rd, pop_e, s_rd;
    fifo_word_t w;
    rst_n      = rst;
    m_ready    = rdy;
    fifo_empty = rst ? fe : (fe || (fifo_q.size() == 0));
    @(negedge clk);
    // A word is visible two cycles after its read; occupancy plus in-flight
    // reads must stay within two buffer slots.
    exp_valid = !rst && ((rd_cum_p2 - xfers) > 0);
    pop_e     = exp_valid && rdy;
    exp_rd    = !rst && !fifo_empty && ((rd_cum_p1 - xfers - int'(pop_e)) < 2);
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    chk("m_last", 32'(m_last), 32'(exp_valid && ((xfers % BL) == BL - 1)));
    chk("beat_cnt", 32'(beat_cnt), 32'(xfers % BL));
    if (exp_valid && exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    s_rd = fifo_rd_en;
    if (s_rd) rd_pulses++;
    if (s_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
    if (pop_e && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      xfers++;
      total_xfers++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      rd_cum_p1 = 0;
      rd_cum_p2 = 0;
      xfers     = 0;
    end else begin
      rd_cum_p2 = rd_cum_p1;
      if (s_rd && fifo_q.size() > 0) begin
        w         = fifo_q.pop_front();
        fifo_data = w;
        exp_q.push_back(w);
        rd_cum_p1++;
      end
    end
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(fifo_word_t'(base + i));
  endtask

  initial begin
    int target;
    int pushed;
    int t6_start;
    rst_n      = 1'b1;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    @(posedge clk);
    #1;

    // T1: reset held with a non-empty FIFO
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);

    // T2: streaming 8 words, full throughput, bursts of 4
    load(1, 8);
    first_rd_cyc = -1;
    first_v_cyc  = -1;
    rd_pulses    = 0;
    for (int i = 0; i < 40 && xfers < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("t2_done", 32'(xfers), 32'd8);
    chk("t2_reads", 32'(rd_pulses), 32'd8);
    chk("t2_latency", 32'(first_v_cyc - first_rd_cyc), 32'd2);

    // T3: backpressure
    load(1, 8);
    rd_pulses = 0;
    target    = xfers + 8;
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("t3_reads", 32'(rd_pulses), 32'd2);
    chk("t3_hold", 32'(m_data), 32'h1);
    for (int i = 0; i < 60 && xfers < target; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("t3_done", 32'(xfers), 32'(target));

    // T4: FIFO reports empty mid-stream
    load(16'h100, 8);
    target = xfers + 8;
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b1, 1'b1);
    chk("t4_drained", 32'(m_valid), 32'd0);
    for (int i = 0; i < 60 && xfers < target; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("t4_done", 32'(xfers), 32'(target));

    // T5: reset with two words buffered and beat_cnt=2
    load(16'h180, 8);
    for (int i = 0; i < 40 && (xfers % BL) != 2; i++) cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("t5_pre_beat", 32'(beat_cnt), 32'd2);
    cycle(1'b1, 1'b0, 1'b0);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_beat", 32'(beat_cnt), 32'd0);
    load(16'h200, 8);
    for (int i = 0; i < 40 && xfers < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("t5_done", 32'(xfers), 32'd8);

    // T6: random FIFO fill, empty glitches and sink stalls
    pushed   = 0;
    t6_start = total_xfers;
    for (int i = 0; i < 20000 && (total_xfers - t6_start) < 1000; i++) begin
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(fifo_word_t'($urandom));
        pushed++;
      end
      cycle(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
    end
    chk("t6_count", 32'(total_xfers - t6_start), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
